// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : write-only byte FIFO draining into an 8N1 UART serializer
// Rev 1.0
// ============================================================================
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT    = 868,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [31:0]              uart_dout,
   input  logic                     uart_we,
   output logic                     txd,
   output logic                     tx_busy,
   output logic                     fifo_full,
   output logic [FIFO_DEPTH_LOG2:0] fifo_count,
   output logic                     overflow
);
   localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                     state;
   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]              baud_cnt;
   logic [2:0]                 bit_idx;
   logic [7:0]                 shreg;
   logic                       fifo_empty;
   logic                       baud_done;
   logic                       pop;
   logic                       push;
   logic                       unused_dout;

   assign unused_dout = ^uart_dout[31:8];
   assign fifo_empty  = (fifo_count == '0);
   // count never exceeds DEPTH, so its MSB alone marks full
   assign fifo_full   = fifo_count[FIFO_DEPTH_LOG2];
   assign baud_done   = (baud_cnt == '0);
   assign pop         = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));
   assign push        = uart_we && (!fifo_full || pop);
   assign tx_busy     = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= uart_dout[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fifo_count <= fifo_count + 1'b1;
         else if (pop && !push)
            fifo_count <= fifo_count - 1'b1;
         if (uart_we && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         txd      <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg    <= mem[rd_ptr];
                  txd      <= 1'b0;
                  baud_cnt <= RELOAD;
                  state    <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  txd      <= shreg[0];
                  baud_cnt <= RELOAD;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= RELOAD;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     shreg   <= {1'b0, shreg[7:1]};
                     txd     <= shreg[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  // chain straight into the next start bit when more data is queued
                  if (pop) begin
                     shreg    <= mem[rd_ptr];
                     txd      <= 1'b0;
                     baud_cnt <= RELOAD;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// tb_uart_tx_fifo : UART TX FIFO bench with a queue-based frame model, a line decoder,
// a vector table and directed corner sequences.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int DL2   = 2;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk;
   logic        reset_n;
   logic [31:0] uart_dout;
   logic        uart_we;
   logic        txd;
   logic        tx_busy;
   logic        fifo_full;
   logic [DL2:0] fifo_count;
   logic        overflow;

   int checks = 0;
   int fails  = 0;
   logic chk_en = 1'b0;

   // reference model: queued bytes, byte on the line, position inside its 40-cycle frame
   logic [7:0] m_q[$];
   logic [7:0] m_acc[$];
   logic [7:0] m_cur = 8'h00;
   int         m_pos = -1;
   logic       m_ovf = 1'b0;

   logic [7:0] rx_q[$];

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .uart_dout  (uart_dout),
      .uart_we    (uart_we),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .fifo_full  (fifo_full),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic exp_txd(input int pos, input logic [7:0] b);
      int slot;
      if (pos < 0) return 1'b1;
      slot = pos / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return b[slot-1];
   endfunction

   task automatic model_step();
      bit was_full;
      bit do_pop;
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() != 0) && (m_pos < 0 || m_pos == FRAME - 1);
      if (do_pop) begin
         m_cur = m_q.pop_front();
         m_pos = 0;
      end else if (m_pos == FRAME - 1) begin
         m_pos = -1;
      end else if (m_pos >= 0) begin
         m_pos++;
      end
      if (uart_we) begin
         if (!was_full || do_pop) begin
            m_q.push_back(uart_dout[7:0]);
            m_acc.push_back(uart_dout[7:0]);
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_q.delete();
            m_pos = -1;
            m_ovf = 1'b0;
         end else begin
            model_step();
         end
      end
   end

   // cycle-by-cycle comparison of every output against the model
   initial begin
      logic [6:0] act;
      logic [6:0] exp;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            act = {txd, tx_busy, fifo_full, overflow, fifo_count};
            exp = {exp_txd(m_pos, m_cur), (m_pos >= 0 || m_q.size() != 0),
                   (m_q.size() == DEPTH), m_ovf, 3'(m_q.size())};
            checks++;
            if (act !== exp) begin
               fails++;
               $display("FAIL lockstep t=%0t {txd,busy,full,ovf,count} got=%b exp=%b",
                        $time, act, exp);
            end
         end
      end
   end

   // independent line decoder sampling the 2nd cycle of each bit
   initial begin
      int rx_pos = -1;
      int slot;
      logic [7:0] rx_b = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            rx_pos = -1;
         end else begin
            if (rx_pos < 0 && txd === 1'b0) rx_pos = 0;
            if (rx_pos >= 0) begin
               if (rx_pos % CPB == 1) begin
                  slot = rx_pos / CPB;
                  if (slot >= 1 && slot <= 8) rx_b[slot-1] = txd;
                  if (slot == 9) begin
                     checks++;
                     if (txd !== 1'b1) begin
                        fails++;
                        $display("FAIL stop_bit got=%b exp=1", txd);
                     end
                     rx_q.push_back(rx_b);
                  end
               end
               rx_pos++;
               if (rx_pos == FRAME) rx_pos = -1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic write_byte(input logic [31:0] d);
      @(negedge clk);
      uart_we   = 1'b1;
      uart_dout = d;
      @(negedge clk);
      uart_we   = 1'b0;
      uart_dout = $urandom;
   endtask

   // leaves uart_we high with the last byte set; caller ends the burst
   task automatic burst(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         uart_we   = 1'b1;
         uart_dout = {24'hC0FFEE, 8'(base + 8'(i))};
      end
   endtask

   task automatic wait_rx(input int n, input int budget);
      int c;
      c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (rx_q.size() < n) begin
         fails++;
         $display("FAIL wait_rx got=%0d bytes exp=%0d", rx_q.size(), n);
      end
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while (tx_busy !== 1'b0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("idle_after_drain", 32'(tx_busy), 32'd0);
   endtask

   task automatic wait_pos(input int pos, input int budget);
      int c;
      c = 0;
      while (m_pos != pos && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("reach_frame_pos", m_pos, pos);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [31:0] dout;
      logic [7:0]  exp_byte;
   } vec_t;
   vec_t vecs[5];

   initial begin
      #500000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] sent[10];
      int ok;
      uart_we   = 1'b0;
      uart_dout = 32'h0;
      reset_n   = 1'b1;
      #1 reset_n = 1'b0;
      #1 chk_en  = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_txd",   32'(txd),        32'd1);
      check("reset_busy",  32'(tx_busy),    32'd0);
      check("reset_count", 32'(fifo_count), 32'd0);
      check("reset_full",  32'(fifo_full),  32'd0);
      check("reset_ovf",   32'(overflow),   32'd0);
      reset_n = 1'b1;

      vecs[0] = '{32'hFFFFFF55, 8'h55};
      vecs[1] = '{32'h000000FF, 8'hFF};
      vecs[2] = '{32'h12345600, 8'h00};
      vecs[3] = '{32'hDEADBE80, 8'h80};
      vecs[4] = '{32'h0000A5C3, 8'hC3};
      foreach (vecs[i]) begin
         rx_q.delete();
         write_byte(vecs[i].dout);
         wait_rx(1, 60);
         check("table_byte", 32'(rx_q[0]), 32'(vecs[i].exp_byte));
         wait_idle(10);
      end

      // back-to-back frames
      rx_q.delete();
      burst(8'h01, 3);
      @(negedge clk); uart_we = 1'b0;
      wait_rx(3, 150);
      for (int i = 0; i < 3; i++) check("b2b_byte", 32'(rx_q[i]), 32'(i + 1));
      wait_idle(20);

      // overflow
      rx_q.delete();
      burst(8'hA0, 5);
      @(negedge clk);
      check("ovf_count_after5", 32'(fifo_count), 32'd4);
      check("ovf_full_after5",  32'(fifo_full),  32'd1);
      check("ovf_flag_after5",  32'(overflow),   32'd0);
      uart_dout = 32'h000000A5;
      @(negedge clk); uart_we = 1'b0;
      check("ovf_flag_after6",  32'(overflow),   32'd1);
      check("ovf_count_after6", 32'(fifo_count), 32'd4);
      wait_rx(5, 260);
      for (int i = 0; i < 5; i++) check("ovf_byte", 32'(rx_q[i]), 32'(8'hA0 + i));
      wait_idle(20);
      check("ovf_rx_count", rx_q.size(), 5);
      check("ovf_sticky", 32'(overflow), 32'd1);
      apply_reset();
      check("ovf_cleared", 32'(overflow), 32'd0);

      // full FIFO with push on the stop-end pop edge
      rx_q.delete();
      burst(8'hB0, 5);
      @(negedge clk); uart_we = 1'b0;
      wait_pos(FRAME - 1, 60);
      uart_we = 1'b1; uart_dout = 32'hFFFFFF77;
      @(negedge clk); uart_we = 1'b0;
      check("fullpop_count", 32'(fifo_count), 32'd4);
      check("fullpop_ovf",   32'(overflow),   32'd0);
      check("fullpop_full",  32'(fifo_full),  32'd1);
      wait_rx(6, 260);
      for (int i = 0; i < 5; i++) check("fullpop_byte", 32'(rx_q[i]), 32'(8'hB0 + i));
      check("fullpop_last", 32'(rx_q[5]), 32'h77);
      wait_idle(20);

      // reset during data bit 3 with two bytes queued
      rx_q.delete();
      @(negedge clk); uart_we = 1'b1; uart_dout = 32'h0000003C;
      @(negedge clk); uart_dout = 32'h00000011;
      @(negedge clk); uart_dout = 32'h00000022;
      @(negedge clk); uart_we = 1'b0;
      wait_pos(4 * CPB + 1, 40);
      check("pre_reset_count", 32'(fifo_count), 32'd2);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_txd",   32'(txd),        32'd1);
      check("midrst_count", 32'(fifo_count), 32'd0);
      check("midrst_busy",  32'(tx_busy),    32'd0);
      @(negedge clk); reset_n = 1'b1;
      repeat (100) @(negedge clk);
      check("post_reset_rx", rx_q.size(), 0);
      check("post_reset_txd", 32'(txd), 32'd1);

      // ten spaced writes wrap the pointers twice
      rx_q.delete();
      for (int i = 0; i < 10; i++) begin
         sent[i] = 8'($urandom);
         write_byte({$urandom_range(0, 255) == 0 ? 24'h0 : 24'hABCDEF, sent[i]});
         repeat (40) @(negedge clk);
      end
      wait_rx(10, 100);
      for (int i = 0; i < 10; i++) check("wrap_byte", 32'(rx_q[i]), 32'(sent[i]));
      wait_idle(20);

      // random traffic; every accepted byte must come out in order
      rx_q.delete();
      m_acc.delete();
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         uart_we   = ($urandom_range(0, 99) < (i < 600 ? 12 : 3));
         uart_dout = $urandom;
      end
      @(negedge clk); uart_we = 1'b0;
      wait_idle(400);
      wait_rx(m_acc.size(), 10);
      check("rand_count", rx_q.size(), m_acc.size());
      ok = 1;
      for (int i = 0; i < m_acc.size() && i < rx_q.size(); i++)
         if (rx_q[i] !== m_acc[i]) ok = 0;
      check("rand_order", ok, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-serial UART transmitter that terminates the core's `uart_dout`/`uart_we` peripheral write port. Each `uart_we` pulse pushes the low byte of `uart_dout` into a small FIFO. An 8N1 serializer drains the FIFO onto `txd` at a fixed bit period. The core has no backpressure path, so writes to a full FIFO are dropped and flagged rather than stalling the pipeline.

## Interface

Parameters
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal minimum is 2.
- `FIFO_DEPTH_LOG2`, default 4: FIFO holds 2**`FIFO_DEPTH_LOG2` bytes.

Ports
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `uart_dout` in 32: write data from the core's memory stage; only [7:0] used, [31:8] ignored.
- `uart_we` in 1: write strobe, one byte per high cycle.
- `txd` out 1: serial line, idle high.
- `tx_busy` out 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `fifo_full` out 1: FIFO holds 2**`FIFO_DEPTH_LOG2` entries.
- `fifo_count` out `FIFO_DEPTH_LOG2`+1: number of queued bytes, excluding the byte in the shift register.
- `overflow` out 1: sticky; set when a write is dropped; cleared only by reset.

## Operation

FIFO
- Circular buffer with read/write pointers and an occupancy counter.
- Push: `uart_we`=1 at an edge and (not full, or a pop occurs on the same edge). The byte is stored and the count increments.
- Push when full with no simultaneous pop: byte discarded, `overflow`<=1, contents unchanged.
- Simultaneous push and pop: both happen and the count is unchanged, including when full.
- Pointers wrap modulo depth.

Serializer FSM: IDLE, START, DATA, STOP
- IDLE: if the FIFO is non-empty, pop into an 8-bit shift register, `txd`<=0, baud counter<=`CLKS_PER_BIT`-1, go to START.
- START: hold `txd`=0. When the counter reaches 0, drive bit 0 on `txd`, reload the counter, set bit index 0, go to DATA.
- DATA: hold the current bit. When the counter reaches 0:
  - if bit index is 7: `txd`<=1, go to STOP;
  - otherwise shift right (LSB first), increment the index, reload the counter.
- STOP: hold `txd`=1. When the counter reaches 0:
  - if the FIFO is non-empty: pop, `txd`<=0, reload, go to START (no idle gap);
  - otherwise go to IDLE.
- `txd` is a register output, glitch-free.

Reset (async, any state, mid-frame included)
- `txd`=1, FSM=IDLE, pointers/count=0, `fifo_full`=0, `tx_busy`=0, `overflow`=0.
- The partial frame is abandoned and FIFO contents are discarded.

## Timing

- Latency: with the FSM IDLE and the FIFO empty, a write at edge N is popped at edge N+1. `txd` falls after edge N+1.
- Every bit, start and stop included, lasts exactly `CLKS_PER_BIT` cycles. A frame is 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames are contiguous: the next start bit begins on the cycle after the last stop-bit cycle.
- `fifo_count`, `fifo_full` and `overflow` update on the same edge as the push or pop.
- `tx_busy` deasserts on the edge that returns the FSM to IDLE with the FIFO empty.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH_LOG2`=2.

- Single byte: write `uart_dout`=0xFFFFFF55 once -> `txd` low 1 cycle later for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. Total 40 cycles, then `tx_busy`=0. Upper bits have no effect.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles -> 120 contiguous cycles of three frames with no idle cycle between stop and start. Decoded bytes are 0x01, 0x02, 0x03.
- Overflow: write 0xA0..0xA5 on 6 consecutive cycles -> first byte popped on the second edge; `fifo_count` reaches 4 and `fifo_full`=1 after the 5th write. 6th write dropped, `overflow`=1. Exactly 0xA0..0xA4 are transmitted; `overflow` stays 1 afterwards.
- Full plus simultaneous pop: with the FIFO full, write 0x77 on the edge where the stop bit ends -> pop and push both occur, `fifo_count` stays 4, `overflow` stays 0, and 0x77 is transmitted last.
- Reset mid-frame: drive `reset_n` low during data bit 3 of 0x3C with 2 bytes queued -> `txd`=1 immediately, `fifo_count`=0, `tx_busy`=0. After release, `txd` stays high with no further frames.
- Wrap-around: 10 single writes spaced one frame apart -> pointers wrap twice and all 10 bytes are transmitted in order.
